// File: rtl/l2_burst_responder.sv
// L2 burst responder: accepts one block request at a time, waits a fixed
// latency, then streams the aligned block from a local word memory.
module l2_burst_responder #(
    parameter int B              = 9,
    parameter int W              = 7,
    parameter int L2_DELAY       = 7,
    parameter int RAM_ADDR_WIDTH = 13
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [29:0]               ADDR_TO_L2,
    input  logic                      ADDR_TO_L2_VALID,
    output logic                      ADDR_TO_L2_READY,
    output logic [(2**W)-1:0]         DATA_FROM_L2,
    output logic                      DATA_FROM_L2_VALID,
    input  logic                      DATA_FROM_L2_READY,
    input  logic                      MEM_WR_EN,
    input  logic [RAM_ADDR_WIDTH-1:0] MEM_WR_ADDR,
    input  logic [31:0]               MEM_WR_DATA
);

    localparam int L2_BUS_WIDTH = 2**W;
    localparam int L2_BURST     = 2**(B-W);
    localparam int LANES        = 2**(W-5);
    localparam int CW           = 7;
    localparam int BW           = (B > W) ? (B - W) : 1;
    localparam logic [RAM_ADDR_WIDTH-1:0] BLK_MASK = {RAM_ADDR_WIDTH{1'b1}} << (B - 5);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t                    state, state_n;
    logic [CW-1:0]             dly_cnt, dly_cnt_n;
    logic [BW-1:0]             beat, beat_n;
    logic                      valid_n;
    logic                      load_beat;
    logic                      accept;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [RAM_ADDR_WIDTH-1:0] blk_base;
    logic [L2_BUS_WIDTH-1:0]   rd_data;
    logic [31:0]               mem [2**RAM_ADDR_WIDTH];
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^ADDR_TO_L2[29:RAM_ADDR_WIDTH];

    assign ADDR_TO_L2_READY = (state == IDLE) && DATA_FROM_L2_READY && !RST;
    assign accept           = ADDR_TO_L2_VALID && ADDR_TO_L2_READY;
    assign blk_base         = addr_q & BLK_MASK;

    always_ff @(posedge CLK) begin
        if (MEM_WR_EN) begin
            mem[MEM_WR_ADDR] <= MEM_WR_DATA;
        end
    end

    // Lanes of the beat being registered this edge; a same-edge write is not yet visible.
    always_comb begin
        rd_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_data[32*l +: 32] = mem[blk_base + RAM_ADDR_WIDTH'(int'(beat_n) * LANES + int'(l))];
        end
    end

    always_comb begin
        state_n   = state;
        dly_cnt_n = dly_cnt;
        beat_n    = beat;
        valid_n   = DATA_FROM_L2_VALID;
        load_beat = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = WAIT;
                    dly_cnt_n = '0;
                end
            end
            WAIT: begin
                if (dly_cnt == CW'(L2_DELAY - 1)) begin
                    state_n   = BURST;
                    beat_n    = '0;
                    valid_n   = 1'b1;
                    load_beat = 1'b1;
                end else begin
                    dly_cnt_n = dly_cnt + CW'(1);
                end
            end
            BURST: begin
                if (beat == BW'(L2_BURST - 1)) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else begin
                    beat_n    = beat + BW'(1);
                    load_beat = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            dly_cnt            <= '0;
            beat               <= '0;
            DATA_FROM_L2_VALID <= 1'b0;
            DATA_FROM_L2       <= '0;
        end else if (DATA_FROM_L2_READY) begin
            state              <= state_n;
            dly_cnt            <= dly_cnt_n;
            beat               <= beat_n;
            DATA_FROM_L2_VALID <= valid_n;
            if (load_beat) begin
                DATA_FROM_L2 <= rd_data;
            end
            if (accept) begin
                addr_q <= ADDR_TO_L2[RAM_ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_l2_burst_responder.sv
// Self-checking bench for l2_burst_responder: randomized traffic against an
// edge-count schedule model with a mirrored word memory.
module tb_l2_burst_responder;

    localparam int B        = 9;
    localparam int W        = 7;
    localparam int L2_DELAY = 7;
    localparam int RAW      = 13;
    localparam int BUSW     = 2**W;
    localparam int BURST    = 2**(B-W);
    localparam int LANES    = 2**(W-5);
    localparam int DEPTH    = 2**RAW;
    localparam int BLK      = LANES * BURST;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [29:0]     ADDR_TO_L2 = '0;
    logic            ADDR_TO_L2_VALID = 1'b0;
    logic            ADDR_TO_L2_READY;
    logic [BUSW-1:0] DATA_FROM_L2;
    logic            DATA_FROM_L2_VALID;
    logic            DATA_FROM_L2_READY = 1'b1;
    logic            MEM_WR_EN = 1'b0;
    logic [RAW-1:0]  MEM_WR_ADDR = '0;
    logic [31:0]     MEM_WR_DATA = '0;

    always #5 CLK = ~CLK;

    l2_burst_responder #(
        .B(B), .W(W), .L2_DELAY(L2_DELAY), .RAM_ADDR_WIDTH(RAW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ADDR_TO_L2(ADDR_TO_L2),
        .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID),
        .ADDR_TO_L2_READY(ADDR_TO_L2_READY),
        .DATA_FROM_L2(DATA_FROM_L2),
        .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID),
        .DATA_FROM_L2_READY(DATA_FROM_L2_READY),
        .MEM_WR_EN(MEM_WR_EN),
        .MEM_WR_ADDR(MEM_WR_ADDR),
        .MEM_WR_DATA(MEM_WR_DATA)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: request outstanding flag plus enabled edges since acceptance.
    logic [31:0]     mirror [DEPTH];
    bit              m_busy = 1'b0;
    int unsigned     m_n = 0;
    int unsigned     m_addr = 0;
    logic            exp_valid = 1'b0;
    logic [BUSW-1:0] exp_data = '0;

    task automatic check_val(input string tag, input logic [BUSW-1:0] got, input logic [BUSW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [BUSW-1:0] model_beat(input int unsigned addr, input int unsigned k);
        logic [BUSW-1:0] r;
        int unsigned base;
        base = ((addr % DEPTH) / BLK) * BLK;
        r = '0;
        for (int unsigned l = 0; l < LANES; l++)
            r[32*l +: 32] = mirror[(base + k*LANES + l) % DEPTH];
        return r;
    endfunction

    task automatic step();
        #1;
        check_val("addr_ready", BUSW'(ADDR_TO_L2_READY), BUSW'(!m_busy && DATA_FROM_L2_READY && !RST));
        @(posedge CLK);
        if (RST) begin
            m_busy = 1'b0; m_n = 0; exp_valid = 1'b0; exp_data = '0;
        end else if (DATA_FROM_L2_READY) begin
            if (!m_busy) begin
                if (ADDR_TO_L2_VALID) begin
                    m_busy = 1'b1; m_n = 0; m_addr = ADDR_TO_L2;
                end
            end else begin
                m_n++;
                if (m_n >= L2_DELAY && m_n < L2_DELAY + BURST) begin
                    exp_valid = 1'b1;
                    exp_data  = model_beat(m_addr, m_n - L2_DELAY);
                end else if (m_n == L2_DELAY + BURST) begin
                    m_busy = 1'b0; exp_valid = 1'b0;
                end
            end
        end
        if (MEM_WR_EN) mirror[MEM_WR_ADDR] = MEM_WR_DATA;
        #1;
        check_val("data_valid", BUSW'(DATA_FROM_L2_VALID), BUSW'(exp_valid));
        check_val("data", DATA_FROM_L2, exp_data);
    endtask

    task automatic accept_req(input logic [29:0] addr);
        bit ok = 1'b0;
        ADDR_TO_L2 = addr; ADDR_TO_L2_VALID = 1'b1; DATA_FROM_L2_READY = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = m_busy;
        end
        ADDR_TO_L2_VALID = 1'b0;
        if (!ok) check_val("accept_timeout", BUSW'(ok), BUSW'(1));
    endtask

    task automatic drain();
        DATA_FROM_L2_READY = 1'b1;
        for (int i = 0; i < 200 && m_busy; i++) step();
        if (m_busy) check_val("drain_timeout", BUSW'(m_busy), BUSW'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mirror[i] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            MEM_WR_EN = 1'b1; MEM_WR_ADDR = RAW'(i); MEM_WR_DATA = 32'(i);
            step();
        end
        MEM_WR_EN = 1'b0;
        step();
        RST = 1'b0;
        step();

        // Basic block read with fixed expected words
        accept_req(30'h10);
        repeat (L2_DELAY) step();
        check_val("beat0_const", DATA_FROM_L2, {32'h13, 32'h12, 32'h11, 32'h10});
        repeat (3) step();
        check_val("beat3_const", DATA_FROM_L2, {32'h1F, 32'h1E, 32'h1D, 32'h1C});
        drain();

        // Unaligned and wrapping addresses
        accept_req(30'h1B);   drain();
        accept_req(30'h2010); drain();

        // Write during the burst lands in a later beat
        accept_req(30'h10);
        repeat (L2_DELAY + 1) step();
        MEM_WR_EN = 1'b1; MEM_WR_ADDR = RAW'(13'h1C); MEM_WR_DATA = 32'hDEADBEEF;
        step();
        MEM_WR_EN = 1'b0;
        step();
        check_val("beat3_lane0_wr", BUSW'(DATA_FROM_L2[31:0]), BUSW'(32'hDEADBEEF));
        drain();

        // Reset during the latency wait
        accept_req(30'h20);
        repeat (3) step();
        RST = 1'b1; step();
        RST = 1'b0; step();
        accept_req(30'h20); drain();

        // Back-pressure while beat1 is valid
        accept_req(30'h30);
        repeat (L2_DELAY + 1) step();
        DATA_FROM_L2_READY = 1'b0;
        repeat (3) step();
        drain();

        // Second request held during the burst
        accept_req(30'h40);
        ADDR_TO_L2 = 30'h50; ADDR_TO_L2_VALID = 1'b1;
        repeat (14) step();
        ADDR_TO_L2_VALID = 1'b0;
        drain();

        for (int c = 0; c < 4000; c++) begin
            RST                = ($urandom_range(0, 299) == 0);
            DATA_FROM_L2_READY = ($urandom_range(0, 7) != 0);
            ADDR_TO_L2_VALID   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: ADDR_TO_L2 = 30'h10;
                1: ADDR_TO_L2 = 30'($urandom);
                2: ADDR_TO_L2 = 30'h2000 + 30'($urandom_range(0, 63));
                default: ADDR_TO_L2 = 30'($urandom_range(0, 63));
            endcase
            MEM_WR_EN   = ($urandom_range(0, 4) == 0);
            MEM_WR_ADDR = ($urandom_range(0, 1) == 0) ? RAW'($urandom_range(0, 63)) : RAW'($urandom);
            MEM_WR_DATA = $urandom;
            step();
        end
        RST = 1'b0; MEM_WR_EN = 1'b0; ADDR_TO_L2_VALID = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_burst_responder.md
L2_BURST_RESPONDER -- requirements
Module: l2_burst_responder

Interface
REQ-001 SHALL have parameter B, default 9, log2 of cache block size in bits.
REQ-002 SHALL have parameter W, default 7, log2 of the L2-L1 data bus width in bits.
REQ-003 SHALL have parameter L2_DELAY, default 7, acceptance-to-first-beat latency in enabled cycles, legal range 2..64.
REQ-004 SHALL have parameter RAM_ADDR_WIDTH, default 13, log2 of backing memory depth in 32-bit words.
REQ-005 SHALL derive L2_BUS_WIDTH = 2^W, L2_BURST = 2^(B-W) beats per block and LANES = 2^(W-5) words per beat.
REQ-006 SHALL have port CLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port ADDR_TO_L2, input, 30 bits, word address (byte address bits [31:2]) of the requested block.
REQ-009 SHALL have port ADDR_TO_L2_VALID, input, 1 bit, request present.
REQ-010 SHALL have port ADDR_TO_L2_READY, output, 1 bit, responder can accept a request.
REQ-011 SHALL have port DATA_FROM_L2, output, L2_BUS_WIDTH bits, current beat.
REQ-012 SHALL have port DATA_FROM_L2_VALID, output, 1 bit, beat present.
REQ-013 SHALL have port DATA_FROM_L2_READY, input, 1 bit, requester accepts the beat; also acts as the global enable.
REQ-014 SHALL have port MEM_WR_EN, input, 1 bit, backing-memory word write strobe.
REQ-015 SHALL have port MEM_WR_ADDR, input, RAM_ADDR_WIDTH bits, write word index.
REQ-016 SHALL have port MEM_WR_DATA, input, 32 bits, write data.

Function
REQ-017 SHALL implement states IDLE, WAIT and BURST; the reset state is IDLE.
REQ-018 SHALL drive ADDR_TO_L2_READY = (state==IDLE) & DATA_FROM_L2_READY & !RST, combinationally.
REQ-019 SHALL accept a request at a rising edge where VALID & READY, latch the address, clear the latency counter and enter WAIT.
REQ-020 SHALL allow exactly one outstanding request; VALID asserted outside IDLE is ignored and is not queued.
REQ-021 SHALL freeze the state, counters, DATA_FROM_L2 and DATA_FROM_L2_VALID on any edge where DATA_FROM_L2_READY=0, with no change of any kind.
REQ-022 SHALL, in WAIT, count enabled edges and enter BURST so that beat 0 appears immediately after the L2_DELAY-th enabled edge following acceptance.
REQ-023 SHALL present beat k (k=0..L2_BURST-1) one enabled edge after beat k-1, with VALID=1 throughout BURST.
REQ-024 SHALL place word base+k*LANES+l in lane l of beat k, in bits [32l+31:32l], where base = {latched_addr[RAM_ADDR_WIDTH-1:B-5], (B-5) zeros}.
REQ-025 SHALL ignore ADDR_TO_L2 bits [B-6:0], so a request always returns the whole aligned block starting at beat 0 (no critical-word-first ordering).
REQ-026 SHALL ignore ADDR_TO_L2 bits at and above RAM_ADDR_WIDTH, so addresses beyond the memory depth wrap around.
REQ-027 SHALL return to IDLE with VALID=0 on the enabled edge that consumes the last beat, so READY can be high in the following cycle.
REQ-028 SHALL read each beat's words from memory at the edge that registers that beat.
REQ-029 SHALL perform MEM_WR_EN writes at any time; a write at edge N is visible to any beat registered at edge N+1 or later.
REQ-030 SHALL keep DATA_FROM_L2 unchanged outside BURST.

Reset
REQ-031 SHALL, on a rising edge with RST=1, force state IDLE, clear both counters, and set DATA_FROM_L2_VALID=0 and DATA_FROM_L2=0.
REQ-032 SHALL, when reset occurs mid-request, abort the request with no further beats, and keep the memory contents.
REQ-033 SHALL hold ADDR_TO_L2_READY=0 while RST=1.

Verification
(All scenarios use the default parameters and preload word i = i.)
REQ-034 SHALL cover: request 0x10 accepted at edge E0 with READY held high -> beats at E0+7..E0+10: beat0 = {0x13,0x12,0x11,0x10} (lane3..lane0), beat1 = words 0x14..0x17, beat2 = words 0x18..0x1B, beat3 = words 0x1C..0x1F; ADDR READY high again after E0+11.
REQ-035 SHALL cover: request 0x1B -> data identical to request 0x10; request 0x2010 -> data identical to request 0x10 (address wrap).
REQ-036 SHALL cover: READY dropped for 3 cycles while beat1 is valid -> beat1 is held stable with VALID=1, and every later event shifts by exactly 3 cycles.
REQ-037 SHALL cover: a second request held VALID during BURST -> it is not accepted until the cycle after beat3 is consumed, and then returns its own block correctly.
REQ-038 SHALL cover: RST pulsed for 1 cycle during WAIT -> VALID is never asserted, READY is high in the cycle after RST falls, and a new request returns the preloaded data.
REQ-039 SHALL cover: a write of 0xDEADBEEF to word 0x1C during beat1 -> beat3 lane0 = 0xDEADBEEF.
